// File: rtl/card_datapath.sv
// Baccarat card datapath: six card slots, guarded single-slot loading,
// hand scoring, seven-segment display decode and deal bookkeeping.
module card_datapath (
    input  logic       slow_clock,
    input  logic       reset,
    input  logic [3:0] new_card,
    input  logic       load_pcard1,
    input  logic       load_pcard2,
    input  logic       load_pcard3,
    input  logic       load_dcard1,
    input  logic       load_dcard2,
    input  logic       load_dcard3,
    output logic [3:0] pscore,
    output logic [3:0] dscore,
    output logic [3:0] pcard3,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [2:0] cards_dealt,
    output logic       deal_error
);

    // Slots 0..2 are player cards 1..3, slots 3..5 are dealer cards 1..3.
    logic [3:0] slot_q [6];
    logic [3:0] slot_d [6];
    logic [2:0] cards_dealt_q, cards_dealt_d;
    logic       deal_error_q, deal_error_d;

    logic [5:0] load_vec;
    logic       one_load;
    logic       rank_ok;
    logic       target_empty;
    logic       accept;
    logic       reject;

    // Baccarat value of a rank: face cards, tens and empty slots count 0.
    function automatic logic [3:0] card_value(input logic [3:0] rank);
        return (rank >= 4'd1 && rank <= 4'd9) ? rank : 4'd0;
    endfunction

    // Hand score mod 10; the 5-bit sum never exceeds 27 so two reductions suffice.
    function automatic logic [3:0] hand_score(input logic [3:0] a,
                                              input logic [3:0] b,
                                              input logic [3:0] c);
        logic [4:0] sum;
        sum = {1'b0, card_value(a)} + {1'b0, card_value(b)} + {1'b0, card_value(c)};
        if (sum >= 5'd20)
            sum = sum - 5'd20;
        else if (sum >= 5'd10)
            sum = sum - 5'd10;
        return sum[3:0];
    endfunction

    // Active-low gfedcba pattern for a slot's rank; empty slot is blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] rank);
        case (rank)
            4'd1:    return 7'b0001000;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            4'd10:   return 7'b1000000;
            4'd11:   return 7'b1100001;
            4'd12:   return 7'b0011000;
            4'd13:   return 7'b0001001;
            default: return 7'b1111111;
        endcase
    endfunction

    assign load_vec = {load_dcard3, load_dcard2, load_dcard1,
                       load_pcard3, load_pcard2, load_pcard1};

    // Decide whether this edge's load attempt is accepted or rejected.
    always_comb begin
        one_load     = $onehot(load_vec);
        rank_ok      = (new_card >= 4'd1) && (new_card <= 4'd13);
        target_empty = 1'b0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (load_vec[i] && (slot_q[i] == 4'd0))
                target_empty = 1'b1;
        end
        accept = one_load && rank_ok && target_empty;
        reject = (|load_vec) && !accept;
    end

    // Next-state for slots, deal counter and sticky error flag.
    always_comb begin
        for (int unsigned i = 0; i < 6; i++)
            slot_d[i] = (accept && load_vec[i]) ? new_card : slot_q[i];
        cards_dealt_d = cards_dealt_q;
        if (accept && (cards_dealt_q != 3'd6))
            cards_dealt_d = cards_dealt_q + 3'd1;
        deal_error_d = deal_error_q | reject;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 6; i++)
                slot_q[i] <= '0;
            cards_dealt_q <= '0;
            deal_error_q  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 6; i++)
                slot_q[i] <= slot_d[i];
            cards_dealt_q <= cards_dealt_d;
            deal_error_q  <= deal_error_d;
        end
    end

    // Combinational outputs straight from the slot registers.
    always_comb begin
        pscore      = hand_score(slot_q[0], slot_q[1], slot_q[2]);
        dscore      = hand_score(slot_q[3], slot_q[4], slot_q[5]);
        pcard3      = card_value(slot_q[2]);
        HEX0        = seg_decode(slot_q[0]);
        HEX1        = seg_decode(slot_q[1]);
        HEX2        = seg_decode(slot_q[2]);
        HEX3        = seg_decode(slot_q[3]);
        HEX4        = seg_decode(slot_q[4]);
        HEX5        = seg_decode(slot_q[5]);
        cards_dealt = cards_dealt_q;
        deal_error  = deal_error_q;
    end

endmodule

// File: tb/tb_card_datapath.sv
// Directed bench for card_datapath with hand-computed expectations.
module tb_card_datapath;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_10    = 7'b1000000;
    localparam logic [6:0] SEG_Q     = 7'b0011000;
    localparam logic [6:0] SEG_K     = 7'b0001001;

    // Load mask bit positions
    localparam int P1 = 0, P2 = 1, P3 = 2, D1 = 3, D2 = 4, D3 = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] new_card = '0;
    logic [5:0] ld = '0;
    logic [3:0] pscore, dscore, pcard3;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic [2:0] cards_dealt;
    logic       deal_error;

    int n_checks = 0;
    int n_errors = 0;

    card_datapath dut (
        .slow_clock  (clk),
        .reset       (rst),
        .new_card    (new_card),
        .load_pcard1 (ld[0]),
        .load_pcard2 (ld[1]),
        .load_pcard3 (ld[2]),
        .load_dcard1 (ld[3]),
        .load_dcard2 (ld[4]),
        .load_dcard3 (ld[5]),
        .pscore      (pscore),
        .dscore      (dscore),
        .pcard3      (pcard3),
        .HEX0        (hex0),
        .HEX1        (hex1),
        .HEX2        (hex2),
        .HEX3        (hex3),
        .HEX4        (hex4),
        .HEX5        (hex5),
        .cards_dealt (cards_dealt),
        .deal_error  (deal_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        ld  = '0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One load attempt: drive at negedge, capture on posedge, sample 1 unit later.
    task automatic load(input int slot_mask, input logic [3:0] card);
        @(negedge clk);
        ld       = slot_mask[5:0];
        new_card = card;
        @(posedge clk);
        #1;
        ld = '0;
    endtask

    function automatic int bit_of(input int idx);
        return 1 << idx;
    endfunction

    initial begin
        // Reset state
        apply_reset();
        check("rst_pscore", pscore, 0);
        check("rst_dscore", dscore, 0);
        check("rst_pcard3", pcard3, 0);
        check("rst_cards", cards_dealt, 0);
        check("rst_err", deal_error, 0);
        check("rst_hex0", hex0, SEG_BLANK);
        check("rst_hex3", hex3, SEG_BLANK);
        check("rst_hex5", hex5, SEG_BLANK);

        // Alternating deal: p1=7, d1=K, p2=8, d2=4
        load(bit_of(P1), 4'd7);
        check("first_cap_hex0", hex0, SEG_7);
        check("first_cap_pscore", pscore, 7);
        load(bit_of(D1), 4'd13);
        load(bit_of(P2), 4'd8);
        load(bit_of(D2), 4'd4);
        check("s1_pscore", pscore, 5);
        check("s1_dscore", dscore, 4);
        check("s1_pcard3", pcard3, 0);
        check("s1_cards", cards_dealt, 4);
        check("s1_err", deal_error, 0);
        check("s1_hex3", hex3, SEG_K);
        check("s1_hex1", hex1, SEG_8);
        // Idle edges change nothing
        repeat (3) @(posedge clk);
        #1;
        check("idle_cards", cards_dealt, 4);
        check("idle_pscore", pscore, 5);

        // 9+9+6 = 24 -> 4
        apply_reset();
        load(bit_of(P1), 4'd9);
        load(bit_of(P2), 4'd9);
        load(bit_of(P3), 4'd6);
        check("s2_pscore", pscore, 4);
        check("s2_pcard3", pcard3, 6);
        check("s2_hex2", hex2, SEG_6);

        // 9+9+Q = 18 -> 8
        apply_reset();
        load(bit_of(P1), 4'd9);
        load(bit_of(P2), 4'd9);
        load(bit_of(P3), 4'd12);
        check("s2q_pcard3", pcard3, 0);
        check("s2q_hex2", hex2, SEG_Q);
        check("s2q_pscore", pscore, 8);
        // Max sum 9+9+9 = 27 -> 7 on the dealer side, then fill all six
        load(bit_of(D1), 4'd9);
        load(bit_of(D2), 4'd9);
        load(bit_of(D3), 4'd9);
        check("max_dscore", dscore, 7);
        check("full_cards", cards_dealt, 6);
        check("full_err", deal_error, 0);
        load(bit_of(D3), 4'd1);
        check("seventh_err", deal_error, 1);
        check("seventh_cards", cards_dealt, 6);
        check("seventh_dscore", dscore, 7);

        // 10 + A + 9 = 20 -> 0, tens and ace displays
        apply_reset();
        load(bit_of(D1), 4'd10);
        load(bit_of(D2), 4'd1);
        load(bit_of(D3), 4'd9);
        check("ten_dscore", dscore, 0);
        check("ten_hex3", hex3, SEG_10);
        check("ace_hex4", hex4, SEG_A);

        // Two loads at once are rejected
        apply_reset();
        load(bit_of(P1) | bit_of(D1), 4'd5);
        check("dbl_hex0", hex0, SEG_BLANK);
        check("dbl_hex3", hex3, SEG_BLANK);
        check("dbl_err", deal_error, 1);
        check("dbl_cards", cards_dealt, 0);

        // Invalid rank rejected, then valid load still works, error sticks
        apply_reset();
        load(bit_of(D2), 4'd14);
        check("bad14_hex4", hex4, SEG_BLANK);
        check("bad14_err", deal_error, 1);
        load(bit_of(D2), 4'd3);
        check("after_bad_dscore", dscore, 3);
        check("after_bad_hex4", hex4, SEG_3);
        check("after_bad_err", deal_error, 1);
        check("after_bad_cards", cards_dealt, 1);
        apply_reset();
        load(bit_of(P1), 4'd0);
        check("bad0_err", deal_error, 1);
        check("bad0_hex0", hex0, SEG_BLANK);
        check("bad0_cards", cards_dealt, 0);

        // Held load: captures once, later edges rejected
        apply_reset();
        @(negedge clk);
        ld       = 6'(bit_of(P1));
        new_card = 4'd2;
        @(posedge clk);
        #1;
        check("hold1_err", deal_error, 0);
        @(negedge clk);
        new_card = 4'd5;
        @(posedge clk);
        #1;
        check("hold2_err", deal_error, 1);
        @(negedge clk);
        new_card = 4'd6;
        @(posedge clk);
        #1;
        ld = '0;
        check("hold_hex0", hex0, SEG_2);
        check("hold_pscore", pscore, 2);
        check("hold_cards", cards_dealt, 1);

        // Asynchronous reset mid-deal after five cards
        apply_reset();
        load(bit_of(P1), 4'd3);
        load(bit_of(D1), 4'd4);
        load(bit_of(P2), 4'd5);
        load(bit_of(D2), 4'd6);
        load(bit_of(P3), 4'd7);
        check("pre_async_cards", cards_dealt, 5);
        #2;
        rst = 1'b1;
        #1;
        check("async_cards", cards_dealt, 0);
        check("async_pscore", pscore, 0);
        check("async_dscore", dscore, 0);
        check("async_pcard3", pcard3, 0);
        check("async_hex2", hex2, SEG_BLANK);
        check("async_hex4", hex4, SEG_BLANK);
        // Reset dominates a simultaneous load
        @(negedge clk);
        ld       = 6'(bit_of(P1));
        new_card = 4'd8;
        @(posedge clk);
        #1;
        check("rst_dom_hex0", hex0, SEG_BLANK);
        check("rst_dom_cards", cards_dealt, 0);
        @(negedge clk);
        rst = 1'b0;
        ld  = '0;
        load(bit_of(P1), 4'd8);
        check("post_rst_hex0", hex0, SEG_8);
        check("post_rst_cards", cards_dealt, 1);
        check("post_rst_err", deal_error, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

    // Hard stop so the run cannot hang.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
